// File: rtl/truth_table_scanner.sv
// Truth-table scanner: sweeps every input vector of an N_IN-input function block,
// captures its output, counts ones and compares against a latched expected table.
//
// state | meaning
// IDLE  | waiting for start; results from the previous scan held
// SCAN  | presenting x, settling, then sampling y once per vector
module truth_table_scanner #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        x,
    input  logic                   y,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   tbl,
    output logic [N_IN:0]          ones,
    output logic [N_IN:0]          mismatch_cnt,
    output logic                   match,
    output logic [N_IN-1:0]        first_err,
    output logic                   err_valid
);

    localparam int TW = 1 << N_IN;
    localparam logic [3:0] CNT_LD = 4'(SETTLE - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t         state, state_nxt;
    logic           accept, sample, last, miss;
    logic [3:0]     cnt;
    logic [TW-1:0]  exp_q;

    assign miss = y ^ exp_q[x];

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (cnt == 4'd0) begin
                    sample = 1'b1;
                    if (x == {N_IN{1'b1}}) begin
                        last      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tbl          <= '0;
            ones         <= '0;
            mismatch_cnt <= '0;
            match        <= 1'b0;
            first_err    <= '0;
            err_valid    <= 1'b0;
            cnt          <= 4'd0;
            exp_q        <= '0;
        end else begin
            done <= last;
            if (accept) begin
                exp_q        <= expected;
                tbl          <= '0;
                ones         <= '0;
                mismatch_cnt <= '0;
                match        <= 1'b0;
                first_err    <= '0;
                err_valid    <= 1'b0;
                x            <= '0;
                busy         <= 1'b1;
                cnt          <= CNT_LD;
            end else if (state == SCAN) begin
                if (!sample) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    tbl[x] <= y;
                    if (y) ones <= ones + (N_IN+1)'(1);
                    if (miss) begin
                        mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
                        if (!err_valid) begin
                            first_err <= x;
                            err_valid <= 1'b1;
                        end
                    end
                    x   <= x + N_IN'(1);
                    cnt <= CNT_LD;
                    // match must include the vector being sampled on this same edge
                    if (last) begin
                        busy  <= 1'b0;
                        match <= (mismatch_cnt == '0) && !miss;
                    end
                end
            end
        end
    end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus/capture engine for the lab's combinational function blocks. On a start pulse it drives every input vector of an N-input, single-output function block in ascending order. It samples the block's output for each vector and assembles the complete truth table. It also counts ones, compares the table against an expected table, and reports the first mismatching vector. It sits on the bench side of the function block: its `x` output feeds the block's input bus, and the block's `y` returns to it.

## Interface
Parameters:
- `N_IN`, 5, width of the function input bus; the table has 2^N_IN entries.
- `SETTLE`, 1, clock cycles each vector is held before `y` is sampled; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  scan request, sampled on `clk`.
- `expected`  in  2^N_IN  expected truth table; bit i is the expected `y` for `x`=i.
- `x`  out  N_IN  vector driven to the function block.
- `y`  in  1  function block output.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse when a scan completes.
- `table`  out  2^N_IN  captured truth table; bit i holds `y` sampled for `x`=i.
- `ones`  out  N_IN+1  number of 1 bits in the captured table.
- `mismatch_cnt`  out  N_IN+1  number of bits where `table` differs from the latched `expected`.
- `match`  out  1  high when the completed scan had zero mismatches.
- `first_err`  out  N_IN  lowest vector index that mismatched.
- `err_valid`  out  1  high once `first_err` holds a valid index.

## Operation
- Reset values: `x`=0, `busy`=0, `done`=0, `table`=0, `ones`=0, `mismatch_cnt`=0, `match`=0, `first_err`=0, `err_valid`=0. The FSM resets to IDLE and the settle counter to 0.
- FSM states:
  - IDLE: on `start`=1, capture `expected` into an internal register. Clear `table`, `ones`, `mismatch_cnt`, `match`, `first_err` and `err_valid`. Set `x`=0, `busy`=1, settle counter=SETTLE-1, and go to SCAN.
  - SCAN, settle counter nonzero: decrement the counter; `x` holds.
  - SCAN, settle counter zero (sample edge):
    - Write `table[x]`<=`y`.
    - If `y`=1, increment `ones`.
    - If `y` differs from the latched expected bit at index `x`: increment `mismatch_cnt`. If `err_valid`=0, also set `first_err`<=`x` and `err_valid`<=1.
    - Then `x`<=`x`+1 modulo 2^N_IN and reload the counter with SETTLE-1.
  - Final sample (`x`=2^N_IN-1): perform the normal sample update and wrap `x` to 0. Then `busy`<=0, `done`<=1, and go to IDLE. `match`<=1 if the final mismatch count, including this vector, is 0.
- Widths: `ones` and `mismatch_cnt` never wrap; their maximum is 2^N_IN, which fits in N_IN+1 bits.
- Output hold: all result outputs hold until the next accepted start.
- `expected` changes during a scan are ignored; only the value latched at start is used.
- `start` while `busy`=1 is ignored and does not restart or extend the scan.
- `start` in the same cycle that `done` is high is accepted, because the FSM is already in IDLE. Results clear at that edge.
- `rst_n` low mid-scan: all state returns to reset values immediately and asynchronously. No `done` pulse is issued and partial results are discarded.

## Timing
- Edge t0: start is accepted. `x`=0 is visible in the cycle after t0.
- Sample edges: vector i is sampled at edge t0+(i+1)·SETTLE. Each vector is therefore presented for exactly SETTLE full cycles before its sample edge.
- `done` is high for exactly one cycle, following edge t0+2^N_IN·SETTLE. `busy` drops at that same edge.
- Result validity: `table`, `ones`, `mismatch_cnt`, `match`, `first_err` and `err_valid` are final and valid in the `done` cycle.
- Scan length: 2^N_IN·SETTLE cycles. With the defaults this is 32 cycles.
- Inputs: `y` is treated as combinational from `x`; no synchronizer.

## Test plan
- Identity function, defaults (`y`=`x[0]`, `expected`=32'hAAAAAAAA): `table`=32'hAAAAAAAA, `ones`=16, `mismatch_cnt`=0, `match`=1, `err_valid`=0. `done` must be high exactly 32 cycles after the start edge.
- Constant 0 with a wrong expectation (`y`=0, `expected`=32'h00000010): `table`=0, `ones`=0, `mismatch_cnt`=1, `first_err`=4, `err_valid`=1, `match`=0.
- SETTLE=3, `y`=&`x` (AND of all five bits), `expected`=32'h80000000:
  - each `x` value is held 3 cycles;
  - `done` is high 96 cycles after start;
  - `table`=32'h80000000, `ones`=1, `match`=1.
- Start handling:
  - pulse `start` again at cycle 10 of a scan: no effect, `done` still at cycle 32;
  - assert `start` during the `done` cycle: a new scan begins and results clear on that edge.
- Async reset: drop `rst_n` at cycle 17 of a scan. All outputs read 0 immediately, with no `done` pulse. A fresh start then completes normally.
- All-ones function (`y`=1, `expected`=0):
  - `ones`=32 and `mismatch_cnt`=32, exercising the full N_IN+1 width;
  - `first_err`=0 and `match`=0;
  - `x`=0 after the scan (wrap).
